segre_pipeline_ctrl: RTL and testbench
======================================

Name: segre_pipeline_ctrl

Overview:
Central hazard and sequencing controller for the segre 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates the per-stage block (hold flip-flops) and inject-NOP (bubble) controls, and the fetch redirect select.
- Resolves three events: load-use hazards between ID and EX, taken branch/JAL/JALR redirects from EX, and multi-cycle memory waits in MEM.
- Detects memory timeouts with a small FSM plus a wait counter.

Parameters:
REG_SIZE, segre_pkg::REG_SIZE, register address width
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before error (>=2)
CNT_W, 32, perf counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
valid_id_i  in  1  ID holds a valid instruction
id_rs1_addr_i  in  REG_SIZE  ID source 1
id_rs1_used_i  in  1  ID reads rs1
id_rs2_addr_i  in  REG_SIZE  ID source 2
id_rs2_used_i  in  1  ID reads rs2
valid_ex_i  in  1  EX holds a valid instruction
ex_memop_rd_i  in  1  EX instruction is a load
ex_rf_waddr_i  in  REG_SIZE  EX destination
tkbr_i  in  1  EX branch taken
is_jaljalr_i  in  1  EX is JAL/JALR
mem_req_i  in  1  MEM instruction is a valid memop
mem_ready_i  in  1  memory response this cycle
block_if_o / block_id_o / block_ex_o / block_mem_o  out  1 each  hold stage registers
inject_nops_ex_o / inject_nops_mem_o / inject_nops_wb_o  out  1 each  bubble into the named stage
flush_id_o  out  1  kill the IF/ID register (wrong path)
pc_sel_o  out  1  1 = fetch from EX new_pc
state_o  out  2  FSM state (debug)
mem_err_o  out  1  sticky timeout error
stall_ld_cnt_o / mem_wait_cnt_o / redirect_cnt_o  out  CNT_W each  perf counters

Behaviour:
Reset: all outputs are 0, state = RUN, and the timeout counter is 0.
Outputs are Mealy: they are combinational from the state and the current inputs. They apply to the same clock edge.
The redirect condition is redir = valid_ex_i & (tkbr_i | is_jaljalr_i).

A load-use hazard ld_use is 1 when all of the following hold:
- valid_id_i & valid_ex_i & ex_memop_rd_i
- ex_rf_waddr_i != 0
- the EX destination matches an ID source that is read: (id_rs1_used_i & rs1 == waddr) | (id_rs2_used_i & rs2 == waddr)

FSM states: RUN=0, MEM_WAIT=1, ERROR=2. The value 3 is unreachable and is decoded as ERROR.

RUN:
- If mem_req_i & !mem_ready_i: go to MEM_WAIT. In the same cycle, assert block_if/id/ex/mem and inject_nops_wb. Ignore redir and ld_use.
- Else if redir: pc_sel=1, flush_id=1, inject_nops_ex=1. No blocking. ld_use is ignored because the ID instruction is wrong-path.
- Else if ld_use: block_if=1, block_id=1, inject_nops_ex=1. This is a one-cycle bubble; the hazard clears on its own next cycle.
- Else: all outputs 0.

MEM_WAIT:
- While the memory wait lasts: block_if/id/ex/mem=1 and inject_nops_wb=1. The timeout counter increments.
- When mem_ready_i=1: go to RUN and clear the counter. The outputs follow the RUN rules in that same cycle, so a pending redir or ld_use is serviced immediately. EX inputs are stable because EX was held.
- If the counter reaches MEM_TIMEOUT-1 and mem_ready_i=0: go to ERROR.
- The counter saturates and never wraps.

ERROR:
- All block_* outputs = 1, inject_nops_wb = 1, mem_err_o = 1.
- The FSM stays in ERROR until rst_i.

Simultaneous events: priority is ERROR, then memory wait, then redirect, then load-use.
Reset mid-operation: takes effect on the next edge regardless of state. A reset during MEM_WAIT returns to RUN with no error.
mem_req_i & mem_ready_i in the same cycle is a single-cycle access and causes no stall.

Optional Feature:
Macro SEGRE_CTRL_PERF_EN.
- Defined: the perf counters are implemented.
  - stall_ld_cnt_o increments for each ld_use stall cycle that is actually taken.
  - mem_wait_cnt_o increments for each cycle in which MEM_WAIT blocking is applied, including the entry cycle.
  - redirect_cnt_o increments for each serviced redirect.
  - All three reset to 0 and saturate at all-ones.
- Undefined: the perf counter ports are tied to 0 and no counter flops exist.

Decomposition:
segre_pkg gains:
- pipe_ctrl_state_e (RUN, MEM_WAIT, ERROR), 2-bit
- the constant MEM_TIMEOUT_DEF = 64

Natural sub-module: segre_hazard_unit. It is purely combinational, computing ld_use and redir from the ID/EX fields. The parent holds the FSM, the counters and the output priority mux.

Test Plan:
1. Load followed by dependent instruction:
   - Stimulus: EX is a load with waddr=5; ID reads rs1=5 (used).
   - Response: exactly one cycle of block_if=block_id=inject_nops_ex=1. Next cycle, with EX now the bubble, all outputs are 0.
   - x0 check: repeat with waddr=0; no stall occurs.
2. Taken branch:
   - Stimulus: tkbr_i=1 with valid_ex_i=1, and ld_use also true.
   - Response: pc_sel=flush_id=inject_nops_ex=1 for one cycle; block_if=0. redirect_cnt increments by 1 when SEGRE_CTRL_PERF_EN is defined.
3. Memory wait of 3 cycles:
   - Stimulus: mem_req_i=1; mem_ready_i rises on the 4th cycle.
   - Response: state_o=1 for 3 cycles with all blocks and inject_nops_wb=1, then RUN. mem_wait_cnt=3.
4. Memory wait with a pending JAL:
   - Stimulus: is_jaljalr_i=1 held during MEM_WAIT.
   - Response: pc_sel=0 while waiting; pc_sel=1 exactly in the mem_ready_i cycle.
5. Timeout:
   - Stimulus: MEM_TIMEOUT=4; mem_req_i=1 and mem_ready_i=0 forever.
   - Response: state_o=2 and mem_err_o=1 after 4 wait cycles, held until rst_i. Asserting rst_i for 1 cycle returns state=RUN, err=0 and counters=0.
6. Reset mid-MEM_WAIT:
   - Stimulus: rst_i is asserted during the 2nd wait cycle.
   - Response: all outputs are 0 and state=RUN on the next cycle.

Source files
------------

// File: rtl/segre_pkg.sv
// segre_pkg: shared widths, defaults and pipeline-controller state encoding
package segre_pkg;
    localparam int REG_SIZE        = 5;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } pipe_ctrl_state_e;
endpackage

// File: rtl/segre_hazard_unit.sv
// segre_hazard_unit: combinational load-use and redirect detection from ID/EX fields
module segre_hazard_unit #(
    parameter int REG_SIZE = segre_pkg::REG_SIZE
) (
    input  logic                valid_id_i,
    input  logic [REG_SIZE-1:0] id_rs1_addr_i,
    input  logic                id_rs1_used_i,
    input  logic [REG_SIZE-1:0] id_rs2_addr_i,
    input  logic                id_rs2_used_i,
    input  logic                valid_ex_i,
    input  logic                ex_memop_rd_i,
    input  logic [REG_SIZE-1:0] ex_rf_waddr_i,
    input  logic                tkbr_i,
    input  logic                is_jaljalr_i,
    output logic                ld_use_o,
    output logic                redir_o
);
    logic src_hit;

    assign src_hit  = (id_rs1_used_i && id_rs1_addr_i == ex_rf_waddr_i) ||
                      (id_rs2_used_i && id_rs2_addr_i == ex_rf_waddr_i);
    assign ld_use_o = valid_id_i && valid_ex_i && ex_memop_rd_i && (ex_rf_waddr_i != '0) && src_hit;
    assign redir_o  = valid_ex_i && (tkbr_i || is_jaljalr_i);
endmodule

// File: rtl/segre_pipeline_ctrl.sv
// segre_pipeline_ctrl: hazard/sequencing control (block, bubble, redirect, MEM timeout FSM).
// Optional perf counters enabled by defining SEGRE_CTRL_PERF_EN.
module segre_pipeline_ctrl #(
    parameter int REG_SIZE    = segre_pkg::REG_SIZE,
    parameter int MEM_TIMEOUT = segre_pkg::MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_id_i,
    input  logic [REG_SIZE-1:0] id_rs1_addr_i,
    input  logic                id_rs1_used_i,
    input  logic [REG_SIZE-1:0] id_rs2_addr_i,
    input  logic                id_rs2_used_i,
    input  logic                valid_ex_i,
    input  logic                ex_memop_rd_i,
    input  logic [REG_SIZE-1:0] ex_rf_waddr_i,
    input  logic                tkbr_i,
    input  logic                is_jaljalr_i,
    input  logic                mem_req_i,
    input  logic                mem_ready_i,
    output logic                block_if_o,
    output logic                block_id_o,
    output logic                block_ex_o,
    output logic                block_mem_o,
    output logic                inject_nops_ex_o,
    output logic                inject_nops_mem_o,
    output logic                inject_nops_wb_o,
    output logic                flush_id_o,
    output logic                pc_sel_o,
    output logic [1:0]          state_o,
    output logic                mem_err_o,
    output logic [CNT_W-1:0]    stall_ld_cnt_o,
    output logic [CNT_W-1:0]    mem_wait_cnt_o,
    output logic [CNT_W-1:0]    redirect_cnt_o
);
    import segre_pkg::*;

    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    pipe_ctrl_state_e state_q, state_d;
    logic [TW-1:0]    wait_q;
    logic ld_use, redir, err, stall_mem, run_free, take_redir, take_ld;

    segre_hazard_unit #(.REG_SIZE(REG_SIZE)) u_hazard (
        .valid_id_i    (valid_id_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs2_used_i (id_rs2_used_i),
        .valid_ex_i    (valid_ex_i),
        .ex_memop_rd_i (ex_memop_rd_i),
        .ex_rf_waddr_i (ex_rf_waddr_i),
        .tkbr_i        (tkbr_i),
        .is_jaljalr_i  (is_jaljalr_i),
        .ld_use_o      (ld_use),
        .redir_o       (redir)
    );

    // the unreachable encoding 3 decodes as ERROR
    assign err        = (state_q != RUN) && (state_q != MEM_WAIT);
    assign stall_mem  = !err && !mem_ready_i && (state_q == MEM_WAIT || mem_req_i);
    assign run_free   = !err && !stall_mem;
    assign take_redir = run_free && redir;
    assign take_ld    = run_free && !redir && ld_use;

    assign block_if_o        = err || stall_mem || take_ld;
    assign block_id_o        = err || stall_mem || take_ld;
    assign block_ex_o        = err || stall_mem;
    assign block_mem_o       = err || stall_mem;
    assign inject_nops_ex_o  = take_redir || take_ld;
    assign inject_nops_mem_o = 1'b0;
    assign inject_nops_wb_o  = err || stall_mem;
    assign flush_id_o        = take_redir;
    assign pc_sel_o          = take_redir;
    assign state_o           = state_q;
    assign mem_err_o         = err;

    always_comb begin
        state_d = state_q;
        if (err)
            state_d = ERROR;
        else if (state_q == RUN)
            state_d = stall_mem ? MEM_WAIT : RUN;
        else
            state_d = mem_ready_i ? RUN : (wait_q == T_LAST ? ERROR : MEM_WAIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != MEM_WAIT || mem_ready_i)
                wait_q <= '0;
            else if (wait_q != T_LAST)
                wait_q <= wait_q + TW'(1);
        end
    end

`ifdef SEGRE_CTRL_PERF_EN
    logic [CNT_W-1:0] ld_cnt_q, mw_cnt_q, rd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_cnt_q <= '0;
            mw_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (take_ld && !(&ld_cnt_q))
                ld_cnt_q <= ld_cnt_q + CNT_W'(1);
            if (stall_mem && !(&mw_cnt_q))
                mw_cnt_q <= mw_cnt_q + CNT_W'(1);
            if (take_redir && !(&rd_cnt_q))
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        end
    end

    assign stall_ld_cnt_o = ld_cnt_q;
    assign mem_wait_cnt_o = mw_cnt_q;
    assign redirect_cnt_o = rd_cnt_q;
`else
    assign stall_ld_cnt_o = '0;
    assign mem_wait_cnt_o = '0;
    assign redirect_cnt_o = '0;
`endif
endmodule

// File: tb/tb_segre_pipeline_ctrl.sv
// tb_segre_pipeline_ctrl: vector table, directed corner sequences and random run against a behavioural model
module tb_segre_pipeline_ctrl;
    localparam int RS = segre_pkg::REG_SIZE;
    localparam int T  = 4;
    localparam int CW = 32;
`ifdef SEGRE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic vid, u1, u2, vex, ldop, tk, jal, req, rdy;
    logic [RS-1:0] rs1, rs2, wa;
    logic b_if, b_id, b_ex, b_mem, i_ex, i_mem, i_wb, flush, pcsel, err;
    logic [1:0] st;
    logic [CW-1:0] c_ld, c_mw, c_rd;
    logic [11:0] outs;

    int n_chk = 0, n_pass = 0;
    int m_mode, m_waits, m_ld, m_mw, m_rd;

    typedef struct {
        logic vid; logic [RS-1:0] rs1; logic u1; logic [RS-1:0] rs2; logic u2;
        logic vex; logic ld; logic [RS-1:0] wa; logic tk; logic jal; logic req; logic rdy;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;

    segre_pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .valid_id_i(vid), .id_rs1_addr_i(rs1), .id_rs1_used_i(u1),
        .id_rs2_addr_i(rs2), .id_rs2_used_i(u2),
        .valid_ex_i(vex), .ex_memop_rd_i(ldop), .ex_rf_waddr_i(wa),
        .tkbr_i(tk), .is_jaljalr_i(jal), .mem_req_i(req), .mem_ready_i(rdy),
        .block_if_o(b_if), .block_id_o(b_id), .block_ex_o(b_ex), .block_mem_o(b_mem),
        .inject_nops_ex_o(i_ex), .inject_nops_mem_o(i_mem), .inject_nops_wb_o(i_wb),
        .flush_id_o(flush), .pc_sel_o(pcsel), .state_o(st), .mem_err_o(err),
        .stall_ld_cnt_o(c_ld), .mem_wait_cnt_o(c_mw), .redirect_cnt_o(c_rd)
    );

    assign outs = {b_if, b_id, b_ex, b_mem, i_ex, i_mem, i_wb, flush, pcsel, st, err};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit m_redir();
        return vex && (tk || jal);
    endfunction

    function automatic bit m_lduse();
        return vid && vex && ldop && wa != 0 && ((u1 && rs1 == wa) || (u2 && rs2 == wa));
    endfunction

    // expected outputs: ERROR > memory wait > redirect > load-use
    function automatic logic [11:0] model_out();
        logic [1:0] s = 2'(m_mode);
        if (m_mode == 2) return 12'hF25;
        if (!rdy && (m_mode == 1 || req)) return {4'hF, 3'b001, 2'b00, s, 1'b0};
        if (m_redir()) return {4'h0, 3'b100, 2'b11, s, 1'b0};
        if (m_lduse()) return {4'hC, 3'b100, 2'b00, s, 1'b0};
        return {9'b0, s, 1'b0};
    endfunction

    task automatic tick();
        bit wt;
        if (rst) begin
            m_mode = 0; m_waits = 0; m_ld = 0; m_mw = 0; m_rd = 0;
        end else begin
            wt = m_mode != 2 && !rdy && (m_mode == 1 || req);
            if (m_mode != 2) begin
                if (wt) m_mw++;
                else if (m_redir()) m_rd++;
                else if (m_lduse()) m_ld++;
            end
            if (m_mode == 0 && wt) begin
                m_mode = 1; m_waits = 1;
            end else if (m_mode == 1) begin
                if (rdy) m_mode = 0;
                else if (m_waits == T) m_mode = 2;
                else m_waits++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {vid, u1, u2, vex, ldop, tk, jal, req, rdy} = '0;
        rs1 = '0; rs2 = '0; wa = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_vec(input vec_t v);
        vid = v.vid; rs1 = v.rs1; u1 = v.u1; rs2 = v.rs2; u2 = v.u2;
        vex = v.vex; ldop = v.ld; wa = v.wa; tk = v.tk; jal = v.jal; req = v.req; rdy = v.rdy;
    endtask

    task automatic chk_cnt(input string nm, input int ld_e, input int mw_e, input int rd_e);
        chk({nm, "_ldcnt"}, c_ld, PERF ? ld_e : 0);
        chk({nm, "_mwcnt"}, c_mw, PERF ? mw_e : 0);
        chk({nm, "_rdcnt"}, c_rd, PERF ? rd_e : 0);
    endtask

    initial begin
        //             vid rs1 u1 rs2 u2 vex ld wa tk jal req rdy exp
        tbl[0]  = '{1, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 12'hC80};
        tbl[1]  = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 12'h000};
        tbl[2]  = '{1, 1, 0, 7, 1, 1, 1, 7, 0, 0, 0, 0, 12'hC80};
        tbl[3]  = '{1, 1, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0, 12'h000};
        tbl[4]  = '{1, 5, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 12'h000};
        tbl[5]  = '{0, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 12'h000};
        tbl[6]  = '{1, 5, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 12'h098};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12'h000};
        tbl[8]  = '{1, 5, 1, 0, 0, 1, 1, 5, 1, 0, 1, 0, 12'hF20};
        tbl[9]  = '{1, 5, 1, 0, 0, 1, 1, 5, 0, 0, 1, 1, 12'hC80};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0, 12'h098};

        rst = 1'b1;
        clear_in();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_outs", outs, 0);
        chk_cnt("reset", 0, 0, 0);

        foreach (tbl[i]) begin
            do_reset();
            set_vec(tbl[i]);
            #1;
            chk($sformatf("vec%0d", i), outs, tbl[i].exp);
        end

        // load-use: one bubble, then EX holds the bubble
        do_reset();
        set_vec(tbl[0]);
        #1 chk("lduse_c1", outs, 12'hC80);
        tick();
        vex = 1'b0;
        #1 chk("lduse_c2", outs, 0);
        chk_cnt("lduse", 1, 0, 0);

        // 3-cycle memory wait, ready on the 4th cycle
        do_reset();
        req = 1'b1;
        #1 chk("mw_entry", outs, 12'hF20);
        tick();
        #1 chk("mw_w1", outs, 12'hF22);
        tick();
        #1 chk("mw_w2", outs, 12'hF22);
        tick();
        rdy = 1'b1;
        #1 chk("mw_ready", outs, 12'h002);
        tick();
        clear_in();
        #1 chk("mw_after", outs, 0);
        chk_cnt("mw", 0, 3, 0);

        // pending JAL serviced exactly on the ready cycle
        do_reset();
        req = 1'b1; vex = 1'b1; jal = 1'b1;
        #1 chk("jal_entry", outs, 12'hF20);
        tick();
        #1 chk("jal_w1", outs, 12'hF22);
        tick();
        #1 chk("jal_w2", outs, 12'hF22);
        tick();
        rdy = 1'b1;
        #1 chk("jal_ready", outs, 12'h09A);
        tick();
        clear_in();
        #1 chk_cnt("jal", 0, 3, 1);

        // timeout after T wait cycles, sticky until reset
        do_reset();
        req = 1'b1;
        #1 chk("to_entry", outs, 12'hF20);
        for (int k = 1; k <= T; k++) begin
            tick();
            #1 chk($sformatf("to_w%0d", k), outs, 12'hF22);
        end
        tick();
        #1 chk("to_err", outs, 12'hF25);
        rdy = 1'b1;
        tick();
        tick();
        #1 chk("to_hold", outs, 12'hF25);
        do_reset();
        #1 chk("to_rst", outs, 0);
        chk_cnt("to_rst", 0, 0, 0);

        // reset during the 2nd wait cycle
        do_reset();
        req = 1'b1;
        tick();
        tick();
        #1 chk("rmw_w2", outs, 12'hF22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_in();
        #1 chk("rmw_after", outs, 0);

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) < 2);
            vid  = 1'($urandom_range(0, 1));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            vex  = ($urandom_range(0, 3) != 0);
            ldop = 1'($urandom_range(0, 1));
            tk   = ($urandom_range(0, 5) == 0);
            jal  = ($urandom_range(0, 7) == 0);
            req  = 1'($urandom_range(0, 1));
            rdy  = ($urandom_range(0, 9) < 4);
            rs1  = RS'($urandom_range(0, 3));
            rs2  = RS'($urandom_range(0, 3));
            wa   = RS'($urandom_range(0, 3));
            #1;
            if (!rst) begin
                chk($sformatf("rnd%0d_outs", c), outs, model_out());
                chk_cnt($sformatf("rnd%0d", c), m_ld, m_mw, m_rd);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
